trisc_datapath: RTL and testbench

TRISC_DATAPATH -- requirements
Module: trisc_datapath

---
 rtl/trisc_pkg.sv | 47 ++++
 rtl/trisc_if.sv | 28 ++
 rtl/trisc_ram16x8.sv | 43 ++++
 rtl/trisc_datapath.sv | 87 ++++++++
 tb/tb_trisc_datapath.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trisc_pkg.sv
// Shared definitions for the TRISC accumulator datapath: widths, opcodes and
// the one-hot decode bundle seen by the control unit.
package trisc_pkg;

  localparam int WORD_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_INC = 4'h1,
    OP_CLR = 4'h2,
    OP_JMP = 4'h3,
    OP_LDA = 4'h4,
    OP_STA = 4'h5,
    OP_ADD = 4'h6
  } opcode_t;

  typedef struct packed {
    logic inc;
    logic clr;
    logic jmp;
    logic lda;
    logic sta;
    logic add;
  } decode_t;

  // Unassigned opcodes (0, 7-15) fall through to an all-zero bundle.
  function automatic decode_t decode_op(input logic [3:0] op);
    decode_t d;
    d = '0;
    case (op)
      OP_INC:  d.inc = 1'b1;
      OP_CLR:  d.clr = 1'b1;
      OP_JMP:  d.jmp = 1'b1;
      OP_LDA:  d.lda = 1'b1;
      OP_STA:  d.sta = 1'b1;
      OP_ADD:  d.add = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trisc_if.sv
// Control, program-load and status bundle between the TRISC control unit
// (master) and the datapath (slave).
interface trisc_if;
  import trisc_pkg::*;

  logic  C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14;
  logic  PgmWe;
  addr_t PgmAddr;
  word_t PgmData;

  logic  INC, CLR, JMP, LDA, STA, ADD;
  addr_t PcOut;
  word_t AccOut;
  word_t IrOut;

  modport master (
    output C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14,
    output PgmWe, PgmAddr, PgmData,
    input  INC, CLR, JMP, LDA, STA, ADD, PcOut, AccOut, IrOut
  );

  modport slave (
    input  C0, C1, C2, C3, C4, C5, C7, C8, C9, C10, C11, C12, C13, C14,
    input  PgmWe, PgmAddr, PgmData,
    output INC, CLR, JMP, LDA, STA, ADD, PcOut, AccOut, IrOut
  );

endinterface

// File: rtl/trisc_ram16x8.sv
// 16x8 program/data memory: program-load port wins over the datapath store
// port; reads land in the memory data register one edge after the request.
module trisc_ram16x8
  import trisc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pgm_we,
  input  addr_t pgm_addr,
  input  word_t pgm_data,
  input  logic  dp_we,
  input  logic  rd_en,
  input  addr_t dp_addr,
  input  word_t dp_data,
  output word_t mdr
);

  word_t mem_q [MEM_DEPTH];
  word_t mdr_q, mdr_d;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    mdr_d = mdr_q;
    if (rd_en) mdr_d = mem_q[dp_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so a same-edge
  // read sees the word from before any write on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdr_q <= '0;
    else        mdr_q <= mdr_d;
  end

  // NOTE: the storage array is deliberately not reset; a program loaded
  // while the machine is held in reset must survive.
  always_ff @(posedge clk) begin
    if (pgm_we)     mem_q[pgm_addr] <= pgm_data;
    else if (dp_we) mem_q[dp_addr]  <= dp_data;
  end

  assign mdr = mdr_q;

endmodule

// File: rtl/trisc_datapath.sv
// TRISC accumulator-machine datapath: PC, IR, B, SUM and ACC registers,
// address mux, opcode decode and the shared 16x8 memory.
module trisc_datapath
  import trisc_pkg::*;
(
  input  logic    SysClock,
  input  logic    StartStop,
  trisc_if.slave  bus
);

  addr_t   pc_q, pc_d;
  word_t   ir_q, ir_d;
  word_t   b_q, b_d;
  word_t   sum_q, sum_d;
  word_t   acc_q, acc_d;
  word_t   mdr;
  addr_t   addr;
  logic    dp_we;
  decode_t dec;
  logic    unused_reserved;

  assign unused_reserved = bus.C8 ^ bus.C13;

  assign addr = bus.C3 ? ir_q[3:0] : pc_q;

  // A store in flight when StartStop drops is abandoned rather than landing.
  assign dp_we = bus.C5 & StartStop;

  trisc_ram16x8 u_ram (
    .clk      (SysClock),
    .rst_n    (StartStop),
    .pgm_we   (bus.PgmWe),
    .pgm_addr (bus.PgmAddr),
    .pgm_data (bus.PgmData),
    .dp_we    (dp_we),
    .rd_en    (bus.C4),
    .dp_addr  (addr),
    .dp_data  (acc_q),
    .mdr      (mdr)
  );

  always_comb begin
    pc_d = pc_q;
    if (bus.C0)      pc_d = '0;
    else if (bus.C1) pc_d = ir_q[3:0];
    else if (bus.C2) pc_d = pc_q + addr_t'(1);

    ir_d  = bus.C7  ? mdr : ir_q;
    b_d   = bus.C11 ? mdr : b_q;
    sum_d = bus.C14 ? word_t'(acc_q + b_q) : sum_q;

    // C11 doubles as the ACC load-source select when C12 is asserted.
    acc_d = acc_q;
    if (bus.C9)       acc_d = '0;
    else if (bus.C12) acc_d = bus.C11 ? mdr : sum_q;
    else if (bus.C10) acc_d = acc_q + word_t'(1);
  end

  always_ff @(posedge SysClock or negedge StartStop) begin
    if (!StartStop) begin
      pc_q  <= '0;
      ir_q  <= '0;
      b_q   <= '0;
      sum_q <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      acc_q <= acc_d;
    end
  end

  assign dec = decode_op(ir_q[7:4]);

  assign bus.INC    = dec.inc;
  assign bus.CLR    = dec.clr;
  assign bus.JMP    = dec.jmp;
  assign bus.LDA    = dec.lda;
  assign bus.STA    = dec.sta;
  assign bus.ADD    = dec.add;
  assign bus.PcOut  = pc_q;
  assign bus.AccOut = acc_q;
  assign bus.IrOut  = ir_q;

endmodule

// File: tb/tb_trisc_datapath.sv
// Self-checking bench for trisc_datapath: directed instruction scenarios plus
// randomized control words against an integer-arithmetic machine model.
module tb_trisc_datapath;
  import trisc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  trisc_if bus();

  trisc_datapath dut (
    .SysClock  (clk),
    .StartStop (rst_n),
    .bus       (bus)
  );

  // One bit per control line, indexed by its C number (bit 6 unused).
  localparam logic [14:0] B0  = 15'h0001;
  localparam logic [14:0] B1  = 15'h0002;
  localparam logic [14:0] B2  = 15'h0004;
  localparam logic [14:0] B3  = 15'h0008;
  localparam logic [14:0] B4  = 15'h0010;
  localparam logic [14:0] B5  = 15'h0020;
  localparam logic [14:0] B7  = 15'h0080;
  localparam logic [14:0] B9  = 15'h0200;
  localparam logic [14:0] B10 = 15'h0400;
  localparam logic [14:0] B11 = 15'h0800;
  localparam logic [14:0] B12 = 15'h1000;
  localparam logic [14:0] B14 = 15'h4000;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural machine state, plain integers.
  int m_pc, m_acc, m_ir, m_mdr, m_b, m_sum;
  int m_mem [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_dec(input int ir);
    case (ir / 16)
      1:       return 6'b100000;
      2:       return 6'b010000;
      3:       return 6'b001000;
      4:       return 6'b000100;
      5:       return 6'b000010;
      6:       return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] obs_dec();
    return {bus.INC, bus.CLR, bus.JMP, bus.LDA, bus.STA, bus.ADD};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_ir = 0; m_mdr = 0; m_b = 0; m_sum = 0;
  endtask

  // Applies one rising edge worth of register-transfer rules.
  task automatic model_step(input logic [14:0] c, input logic pwe,
                            input logic [3:0] pa, input logic [7:0] pd);
    int addr, n_pc, n_acc, n_ir, n_mdr, n_b, n_sum;
    addr  = c[3] ? (m_ir % 16) : m_pc;
    n_mdr = c[4] ? m_mem[addr] : m_mdr;
    if (pwe)                 m_mem[pa]   = int'(pd);
    else if (c[5] && rst_n)  m_mem[addr] = m_acc;
    if (!rst_n) return;
    n_ir  = c[7]  ? m_mdr : m_ir;
    n_b   = c[11] ? m_mdr : m_b;
    n_sum = c[14] ? (m_acc + m_b) % 256 : m_sum;
    if (c[9])       n_acc = 0;
    else if (c[12]) n_acc = c[11] ? m_mdr : m_sum;
    else if (c[10]) n_acc = (m_acc + 1) % 256;
    else            n_acc = m_acc;
    if (c[0])       n_pc = 0;
    else if (c[1])  n_pc = m_ir % 16;
    else if (c[2])  n_pc = (m_pc + 1) % 16;
    else            n_pc = m_pc;
    m_pc = n_pc; m_acc = n_acc; m_ir = n_ir; m_mdr = n_mdr; m_b = n_b; m_sum = n_sum;
  endtask

  task automatic drive(input logic [14:0] c, input logic pwe,
                       input logic [3:0] pa, input logic [7:0] pd);
    bus.C0  = c[0];  bus.C1  = c[1];  bus.C2  = c[2];  bus.C3  = c[3];
    bus.C4  = c[4];  bus.C5  = c[5];  bus.C7  = c[7];  bus.C8  = c[8];
    bus.C9  = c[9];  bus.C10 = c[10]; bus.C11 = c[11]; bus.C12 = c[12];
    bus.C13 = c[13]; bus.C14 = c[14];
    bus.PgmWe = pwe; bus.PgmAddr = pa; bus.PgmData = pd;
  endtask

  // Controls change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic tick(input logic [14:0] c, input logic pwe = 1'b0,
                      input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
    @(negedge clk);
    drive(c, pwe, pa, pd);
    @(posedge clk);
    model_step(c, pwe, pa, pd);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},  32'(bus.PcOut),  32'(m_pc));
    check({tag, ".acc"}, 32'(bus.AccOut), 32'(m_acc));
    check({tag, ".ir"},  32'(bus.IrOut),  32'(m_ir));
    check({tag, ".dec"}, 32'(obs_dec()),  32'(exp_dec(m_ir)));
  endtask

  // ACC <= v through mem[0]; leaves PC=0 and B=v.
  task automatic load_acc(input logic [7:0] v);
    tick(B0, 1'b1, 4'h0, v);
    tick(B4);
    tick(B11 | B12);
  endtask

  // IR <= v through mem[0]; leaves PC=0, ACC untouched.
  task automatic load_ir(input logic [7:0] v);
    tick(B0, 1'b1, 4'h0, v);
    tick(B4);
    tick(B7);
  endtask

  initial begin
    drive('0, 1'b0, 4'h0, 8'h00);
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst.pc",  32'(bus.PcOut),  32'h0);
    check("rst.acc", 32'(bus.AccOut), 32'h0);
    check("rst.ir",  32'(bus.IrOut),  32'h0);
    check("rst.dec", 32'(obs_dec()),  32'h0);

    // Program load while held in reset.
    for (int i = 0; i < 16; i++) tick('0, 1'b1, 4'(i), 8'($urandom));
    tick('0, 1'b1, 4'h0, 8'h10);
    check("rst.hold.acc", 32'(bus.AccOut), 32'h0);
    @(negedge clk);
    drive('0, 1'b0, 4'h0, 8'h00);
    rst_n = 1'b1;

    // Fetch.
    tick(B4);
    tick(B4);
    tick(B2 | B7);
    check("fetch.ir",  32'(bus.IrOut), 32'h10);
    check("fetch.pc",  32'(bus.PcOut), 32'h1);
    check("fetch.inc", 32'(bus.INC),   32'h1);
    check_state("fetch");

    // LDA 5.
    tick('0, 1'b1, 4'h5, 8'h3C);
    load_ir(8'h45);
    check("lda.dec", 32'(obs_dec()), 32'b000100);
    tick(B3);
    tick(B3 | B4);
    tick(B3 | B4 | B11);
    tick(B11 | B12);
    check("lda.acc", 32'(bus.AccOut), 32'h3C);
    check_state("lda");

    // ADD 6 with carry out discarded.
    load_acc(8'hF0);
    tick('0, 1'b1, 4'h6, 8'h20);
    load_ir(8'h66);
    tick(B3);
    tick(B3 | B4);
    tick(B3 | B4);
    tick(B11);
    tick(B14);
    tick(B12);
    check("add.acc", 32'(bus.AccOut), 32'h10);
    check_state("add");

    // STA 9 and JMP 14 with PC wrap.
    load_acc(8'hA5);
    load_ir(8'h59);
    tick(B3 | B4 | B5);
    check("sta.mem9", 32'(dut.u_ram.mem_q[9]), 32'hA5);
    load_ir(8'h3E);
    check("jmp.dec", 32'(obs_dec()), 32'b001000);
    tick(B1);
    check("jmp.pc", 32'(bus.PcOut), 32'd14);
    tick(B2);
    tick(B2);
    check("wrap.pc", 32'(bus.PcOut), 32'd0);

    // Priorities.
    tick(B9 | B10 | B12);
    check("prio.acc", 32'(bus.AccOut), 32'h0);
    tick(B2);
    tick(B0 | B1 | B2);
    check("prio.pc", 32'(bus.PcOut), 32'h0);
    load_acc(8'h5A);
    tick(B3 | B5, 1'b1, 4'hE, 8'hC3);
    check("prio.mem14", 32'(dut.u_ram.mem_q[14]), 32'hC3);
    tick(B10);
    tick(B10);
    check("inc.acc", 32'(bus.AccOut), 32'h5C);

    // Undefined opcode, then asynchronous reset between edges.
    load_ir(8'h95);
    check("nop.dec", 32'(obs_dec()), 32'h0);
    load_acc(8'h7F);
    tick(B2);
    check_state("prereset");
    @(negedge clk);
    drive('0, 1'b0, 4'h0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.acc",  32'(bus.AccOut), 32'h0);
    check("arst.pc",   32'(bus.PcOut),  32'h0);
    check("arst.ir",   32'(bus.IrOut),  32'h0);
    check("arst.dec",  32'(obs_dec()),  32'h0);
    check("arst.mem9", 32'(dut.u_ram.mem_q[9]), 32'hA5);
    tick(B5);
    check("arst.nowrite", 32'(dut.u_ram.mem_q[0]), 32'h7F);
    @(negedge clk);
    drive('0, 1'b0, 4'h0, 8'h00);
    rst_n = 1'b1;
    tick(B4 | B2);
    tick(B7);
    check("resume.ir", 32'(bus.IrOut), 32'h7F);
    check_state("resume");

    // Randomized control words against the model.
    for (int i = 0; i < 400; i++) begin
      logic [14:0] c;
      logic        pwe;
      c   = 15'($urandom);
      pwe = ($urandom_range(0, 3) == 0);
      tick(c, pwe, 4'($urandom), 8'($urandom));
      check_state($sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("mem%0d", i), 32'(dut.u_ram.mem_q[i]), 32'(m_mem[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
